rv64g_l1_mem_arbiter: RTL and testbench

RV64G_L1_MEM_ARBITER -- requirements
Module: rv64g_l1_mem_arbiter

---
 rtl/rv64g_l1_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_rv64g_l1_mem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv64g_l1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv64g_l1_mem_arbiter
// Brief    : Two-port (I-side / D-side) round-robin arbiter onto a single
//            L1 memory port. Read responses are returned in order and routed
//            back to the issuing port through an in-order ID FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module rv64g_l1_mem_arbiter #(
    parameter int MAX_OUTST = 4,
    parameter int AW        = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    // port 0 : I-side
    input  logic          p0_req_i,
    input  logic          p0_we_i,
    input  logic [7:0]    p0_be_i,
    input  logic [AW-1:0] p0_addr_i,
    input  logic [63:0]   p0_wdata_i,
    output logic          p0_gnt_o,
    output logic          p0_rvalid_o,
    output logic [63:0]   p0_rdata_o,
    // port 1 : D-side
    input  logic          p1_req_i,
    input  logic          p1_we_i,
    input  logic [7:0]    p1_be_i,
    input  logic [AW-1:0] p1_addr_i,
    input  logic [63:0]   p1_wdata_i,
    output logic          p1_gnt_o,
    output logic          p1_rvalid_o,
    output logic [63:0]   p1_rdata_o,
    // memory side
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [7:0]    mem_be_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [63:0]   mem_wdata_o,
    input  logic          mem_gnt_i,
    input  logic          mem_rvalid_i,
    input  logic [63:0]   mem_rdata_i,
    // status
    output logic          err_o,
    output logic [3:0]    outst_o
);

    localparam int                 c_PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam logic [3:0]         c_MAX   = 4'(MAX_OUTST);
    localparam logic [c_PTR_W-1:0] c_LAST  = c_PTR_W'(MAX_OUTST - 1);

    logic                 r_rr;
    logic [3:0]           r_count;
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [MAX_OUTST-1:0] r_ids;
    logic                 r_err;

    logic w_full;
    logic w_empty;
    logic w_elig0;
    logic w_elig1;
    logic w_win_vld;
    logic w_win;
    logic w_win_we;
    logic w_hs;
    logic w_push;
    logic w_pop;
    logic w_head;

    // A full FIFO blocks reads only; a same-cycle pop does not free a slot
    // early, which keeps the grant path independent of mem_rvalid_i.
    assign w_full    = (r_count == c_MAX);
    assign w_empty   = (r_count == 4'd0);
    assign w_elig0   = p0_req_i & (p0_we_i | ~w_full);
    assign w_elig1   = p1_req_i & (p1_we_i | ~w_full);
    assign w_win_vld = w_elig0 | w_elig1;
    // both eligible: pointer decides; otherwise the lone eligible port wins
    assign w_win     = (w_elig0 & w_elig1) ? r_rr : w_elig1;
    assign w_win_we  = w_win ? p1_we_i : p0_we_i;

    // Requests are held stable until granted, so req is implied by a winner.
    assign w_hs      = w_win_vld & mem_gnt_i & rst_ni;
    assign w_push    = w_hs & ~w_win_we;
    assign w_pop     = mem_rvalid_i & ~w_empty;
    assign w_head    = r_ids[r_rptr];

    assign p0_gnt_o    = w_hs & ~w_win;
    assign p1_gnt_o    = w_hs &  w_win;
    assign p0_rvalid_o = w_pop & ~w_head;
    assign p1_rvalid_o = w_pop &  w_head;
    assign p0_rdata_o  = p0_rvalid_o ? mem_rdata_i : 64'd0;
    assign p1_rdata_o  = p1_rvalid_o ? mem_rdata_i : 64'd0;

    assign mem_req_o = w_win_vld & rst_ni;
    assign err_o     = r_err;
    assign outst_o   = r_count;

    // Forward the winning request fields; zero when nothing is requested.
    always_comb begin
        mem_we_o    = 1'b0;
        mem_be_o    = 8'd0;
        mem_addr_o  = '0;
        mem_wdata_o = 64'd0;
        if (mem_req_o) begin
            mem_we_o    = w_win_we;
            mem_be_o    = w_win ? p1_be_i    : p0_be_i;
            mem_addr_o  = w_win ? p1_addr_i  : p0_addr_i;
            mem_wdata_o = w_win ? p1_wdata_i : p0_wdata_i;
        end
    end

    // Round-robin pointer: after a completed handshake prefer the other port.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rr <= 1'b0;
        end else if (w_hs) begin
            r_rr <= ~w_win;
        end
    end

    // In-order ID FIFO of granted reads, pointers wrap modulo MAX_OUTST.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_count <= 4'd0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_ids   <= '0;
        end else begin
            if (w_push) begin
                r_ids[r_wptr] <= w_win;
                r_wptr        <= (r_wptr == c_LAST) ? '0 : r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= (r_rptr == c_LAST) ? '0 : r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error: a response arrived with no read outstanding.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err <= 1'b0;
        end else if (mem_rvalid_i && w_empty) begin
            r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rv64g_l1_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv64g_l1_mem_arbiter
// Brief    : Scoreboard bench for rv64g_l1_mem_arbiter with a simple memory
//            model (fixed read latency, byte-enabled writes).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv64g_l1_mem_arbiter;

    typedef struct { int p; logic [63:0] d; } exp_t;
    typedef struct { int due; logic [63:0] d; } pend_t;

    logic        clk;
    logic        rst_n;
    logic        req   [2];
    logic        we    [2];
    logic [7:0]  be    [2];
    logic [63:0] addr  [2];
    logic [63:0] wdata [2];
    logic        p0_gnt, p1_gnt, p0_rv, p1_rv;
    logic [63:0] p0_rd, p1_rd;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [7:0]  mem_be;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        err;
    logic [3:0]  outst;

    logic        mem_auto;
    int          lat;
    logic        m_rv, s_rv;
    logic [63:0] m_rd, s_rd;

    exp_t        sb   [$];
    pend_t       pend [$];
    int          glog [$];
    int          gcyc [$];
    logic [63:0] mem  [logic [63:0]];
    int          cyc;
    int          rv_cyc;
    int          maxo;
    int          n_cmp;
    int          n_fail;

    assign mem_rvalid = mem_auto ? m_rv : s_rv;
    assign mem_rdata  = mem_auto ? m_rd : s_rd;

    rv64g_l1_mem_arbiter #(.MAX_OUTST(4), .AW(64)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .p0_req_i(req[0]), .p0_we_i(we[0]), .p0_be_i(be[0]), .p0_addr_i(addr[0]),
        .p0_wdata_i(wdata[0]), .p0_gnt_o(p0_gnt), .p0_rvalid_o(p0_rv), .p0_rdata_o(p0_rd),
        .p1_req_i(req[1]), .p1_we_i(we[1]), .p1_be_i(be[1]), .p1_addr_i(addr[1]),
        .p1_wdata_i(wdata[1]), .p1_gnt_o(p1_gnt), .p1_rvalid_o(p1_rv), .p1_rdata_o(p1_rd),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .err_o(err), .outst_o(outst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout, expected normal end");
        $fatal(1);
    end

    // preset contents for locations never written
    function automatic logic [63:0] rd_fn(input logic [63:0] a);
        return {~a[31:0], a[31:0] ^ 32'h5A5A_0000};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic gnt_of(input int p);
        return (p == 1) ? p1_gnt : p0_gnt;
    endfunction

    // Hold a request until granted (bounded), then release it.
    task automatic xact(input int p, input logic w, input logic [7:0] b,
                        input logic [63:0] a, input logic [63:0] d, input int budget);
        int  n;
        logic got;
        n = 0;
        got = 1'b0;
        req[p] = 1'b1; we[p] = w; be[p] = b; addr[p] = a; wdata[p] = d;
        while (!got && n < budget) begin
            @(negedge clk);
            if (gnt_of(p)) got = 1'b1;
            else n++;
        end
        @(posedge clk);
        #1;
        req[p] = 1'b0; we[p] = 1'b0; be[p] = 8'd0; addr[p] = 64'd0; wdata[p] = 64'd0;
        if (!got) begin
            n_cmp++;
            n_fail++;
            $display("FAIL grant_timeout: got no gnt on port %0d, expected a grant", p);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((sb.size() != 0 || pend.size() != 0) && n < 30) begin
            tick();
            n++;
        end
        chk(nm, 64'(sb.size()), 64'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we[p] = 1'b0; be[p] = 8'd0; addr[p] = 64'd0; wdata[p] = 64'd0;
        end
        mem_gnt = 1'b1; s_rv = 1'b0; s_rd = 64'd0; mem_auto = 1'b1; lat = 2;
        repeat (2) @(posedge clk);
        #1;
        pend.delete();
        glog.delete();
        gcyc.delete();
        maxo = 0;
        rst_n = 1'b1;
    endtask

    // Memory model: accept handshakes, apply writes, schedule read data.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_gnt) begin
            if (mem_we) begin
                logic [63:0] cur;
                cur = mem.exists(mem_addr) ? mem[mem_addr] : rd_fn(mem_addr);
                for (int b = 0; b < 8; b++)
                    if (mem_be[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
                mem[mem_addr] = cur;
            end else if (mem_auto) begin
                pend.push_back('{cyc + lat, mem.exists(mem_addr) ? mem[mem_addr] : rd_fn(mem_addr)});
            end
        end
    end

    // Response driver: present the scheduled data in its due cycle.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        m_rv = 1'b0;
        m_rd = 64'd0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            m_rv = 1'b1;
            m_rd = pend[0].d;
            void'(pend.pop_front());
        end
    end

    // Monitor: check every response against the scoreboard, log grants.
    always @(negedge clk) begin
        if (p0_rv || p1_rv) begin
            int          port;
            logic [63:0] data;
            exp_t        e;
            if (p0_rv && p1_rv) chk("both_rvalid", 64'd1, 64'd0);
            port = p1_rv ? 1 : 0;
            data = p1_rv ? p1_rd : p0_rd;
            chk("idle_rdata_zero", port == 1 ? p0_rd : p1_rd, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_rvalid_port", 64'(port), 64'hFFFF);
            end else begin
                e = sb.pop_front();
                chk("rsp_port", 64'(port), 64'(e.p));
                chk("rsp_data", data, e.d);
            end
        end
        if (p0_gnt) begin glog.push_back(0); gcyc.push_back(cyc); end
        if (p1_gnt) begin glog.push_back(1); gcyc.push_back(cyc); end
        if (mem_rvalid) rv_cyc = cyc;
        if (32'(outst) > maxo) maxo = 32'(outst);
    end

    initial begin
        n_cmp = 0; n_fail = 0; cyc = 0; rv_cyc = 0; maxo = 0;
        m_rv = 1'b0; m_rd = 64'd0;
        rst_n = 1'b0;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b1; we[p] = 1'b0; be[p] = 8'hFF; addr[p] = 64'h10; wdata[p] = 64'd0;
        end
        mem_gnt = 1'b1; s_rv = 1'b0; s_rd = 64'd0; mem_auto = 1'b1; lat = 2;

        // reset state with requests pending
        @(negedge clk);
        chk("rst_gnt", {62'd0, p1_gnt, p0_gnt}, 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_outst", 64'(outst), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        do_reset();
        @(negedge clk);
        chk("idle_mem_addr", mem_addr, 64'd0);
        @(posedge clk); #1;

        // continuous reads from both ports, latency 2
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{0, rd_fn(64'h1000 + 64'(8 * i))});
            sb.push_back('{1, rd_fn(64'h2000 + 64'(8 * i))});
        end
        fork
            begin for (int i = 0; i < 4; i++) xact(0, 1'b0, 8'hFF, 64'h1000 + 64'(8 * i), 64'd0, 20); end
            begin for (int j = 0; j < 4; j++) xact(1, 1'b0, 8'hFF, 64'h2000 + 64'(8 * j), 64'd0, 20); end
        join
        drain("alt_drain");
        chk("alt_gnt_count", 64'(glog.size()), 64'd8);
        for (int i = 0; i < glog.size(); i++) chk("alt_gnt_order", 64'(glog[i]), 64'(i % 2));
        chk("alt_outst_max", 64'(maxo), 64'd2);

        // FIFO full: 5 reads on port 1, no responses
        do_reset();
        mem_auto = 1'b0;
        fork
            begin for (int i = 0; i < 5; i++) xact(1, 1'b0, 8'hFF, 64'h5000 + 64'(8 * i), 64'd0, 60); end
            begin
                repeat (8) tick();
                @(negedge clk);
                chk("full_grants", 64'(glog.size()), 64'd4);
                chk("full_outst", 64'(outst), 64'd4);
                @(posedge clk); #1;
                xact(0, 1'b1, 8'hFF, 64'h80, 64'h99, 10);
                chk("full_wr_grants", 64'(glog.size()), 64'd5);
                if (glog.size() >= 5) chk("full_wr_port", 64'(glog[4]), 64'd0);
                sb.push_back('{1, 64'hCAFE});
                s_rd = 64'hCAFE;
                s_rv = 1'b1;
                tick();
                s_rv = 1'b0;
            end
        join
        chk("full_pop_seen", 64'(sb.size()), 64'd0);
        chk("full_fifth_after_pop", 64'(gcyc.size() == 6 && gcyc[5] > rv_cyc), 64'd1);

        // byte-enabled write then read-back on the other port
        do_reset();
        mem[64'h40] = 64'd0;
        xact(0, 1'b1, 8'h0F, 64'h40, 64'h1122334455667788, 10);
        sb.push_back('{1, 64'h0000000055667788});
        xact(1, 1'b0, 8'hFF, 64'h40, 64'd0, 10);
        drain("be_drain");

        // mem_gnt low: no grants, pointer holds
        do_reset();
        sb.push_back('{0, rd_fn(64'h3000)});
        xact(0, 1'b0, 8'hFF, 64'h3000, 64'd0, 10);
        mem_gnt = 1'b0;
        req[0] = 1'b1; addr[0] = 64'h3008; be[0] = 8'hFF;
        req[1] = 1'b1; addr[1] = 64'h4000; be[1] = 8'hFF;
        sb.push_back('{1, rd_fn(64'h4000)});
        sb.push_back('{0, rd_fn(64'h3008)});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("nogntmem_gnt", {62'd0, p1_gnt, p0_gnt}, 64'd0);
            chk("nogntmem_winner_addr", mem_addr, 64'h4000);
        end
        @(posedge clk); #1;
        mem_gnt = 1'b1;
        @(negedge clk);
        chk("nogntmem_first", {62'd0, p1_gnt, p0_gnt}, 64'd2);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        chk("nogntmem_second", {62'd0, p1_gnt, p0_gnt}, 64'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        drain("nogntmem_drain");

        // stray response, then async reset with reads outstanding
        do_reset();
        mem_auto = 1'b0;
        s_rd = 64'hBAD; s_rv = 1'b1;
        tick();
        s_rv = 1'b0;
        @(negedge clk);
        chk("err_set", 64'(err), 64'd1);
        repeat (3) tick();
        @(negedge clk);
        chk("err_sticky", 64'(err), 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) xact(0, 1'b0, 8'hFF, 64'h9000 + 64'(8 * i), 64'd0, 10);
        req[0] = 1'b1; addr[0] = 64'h9100;
        @(negedge clk);
        chk("pre_rst_outst", 64'(outst), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outst", 64'(outst), 64'd0);
        chk("async_rst_err", 64'(err), 64'd0);
        chk("async_rst_gnt", {62'd0, p1_gnt, p0_gnt}, 64'd0);
        chk("async_rst_mem_req", 64'(mem_req), 64'd0);
        req[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        s_rv = 1'b1;
        tick();
        s_rv = 1'b0;
        @(negedge clk);
        chk("post_rst_err", 64'(err), 64'd1);

        // same-cycle push/pop at outst=2, single port stream
        do_reset();
        for (int i = 0; i < 10; i++) sb.push_back('{1, rd_fn(64'h6000 + 64'(8 * i))});
        fork
            begin for (int i = 0; i < 10; i++) xact(1, 1'b0, 8'hFF, 64'h6000 + 64'(8 * i), 64'd0, 20); end
            begin
                repeat (3) tick();
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("pushpop_both", 64'(p1_gnt && p1_rv), 64'd1);
                    chk("pushpop_outst", 64'(outst), 64'd2);
                end
            end
        join
        drain("pushpop_drain");

        // ordering across pointer wrap, latency 4 fills the FIFO
        do_reset();
        lat = 4;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{0, rd_fn(64'h7000 + 64'(8 * i))});
            sb.push_back('{1, rd_fn(64'h8000 + 64'(8 * i))});
        end
        fork
            begin for (int i = 0; i < 5; i++) xact(0, 1'b0, 8'hFF, 64'h7000 + 64'(8 * i), 64'd0, 30); end
            begin for (int j = 0; j < 5; j++) xact(1, 1'b0, 8'hFF, 64'h8000 + 64'(8 * j), 64'd0, 30); end
        join
        drain("wrap_drain");
        chk("wrap_outst_max", 64'(maxo), 64'd4);
        chk("wrap_final_outst", 64'(outst), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
